// File: rtl/armaria_mem_pkg.sv
// Shared memory-subsystem definitions: data port widths and the copy-engine state encoding.
package armaria_mem_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int COUNT_WIDTH = 14;

    typedef enum logic [2:0] {
        COPY_IDLE,
        COPY_READ,
        COPY_LATCH,
        COPY_WRITE,
        COPY_FINISH
    } copy_state_e;

endpackage

// File: rtl/memory_port_mux.sv
// Combinational priority mux for the memory unit data port; the CPU always wins over the engine.
module memory_port_mux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  cpu_request_i,
    input  logic [DATA_WIDTH-1:0] cpu_address_i,
    input  logic [DATA_WIDTH-1:0] cpu_write_data_i,
    input  logic                  cpu_write_enable_i,
    input  logic [DATA_WIDTH-1:0] eng_address_i,
    input  logic [DATA_WIDTH-1:0] eng_write_data_i,
    input  logic                  eng_write_enable_i,
    output logic [DATA_WIDTH-1:0] port_address_o,
    output logic [DATA_WIDTH-1:0] port_write_data_o,
    output logic                  port_write_enable_o
);

    assign port_address_o      = cpu_request_i ? cpu_address_i      : eng_address_i;
    assign port_write_data_o   = cpu_request_i ? cpu_write_data_i   : eng_write_data_i;
    assign port_write_enable_o = cpu_request_i ? cpu_write_enable_i : eng_write_enable_i;

endmodule

// File: rtl/storage_copy_engine.sv
// Block-copy sequencer sharing the memory unit data port with the CPU (CPU has strict priority).
module storage_copy_engine #(
    parameter int DATA_WIDTH  = armaria_mem_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = armaria_mem_pkg::COUNT_WIDTH
) (
    input  logic                   slow_clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  src_address,
    input  logic [DATA_WIDTH-1:0]  dst_address,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   cpu_request,
    input  logic [DATA_WIDTH-1:0]  cpu_address,
    input  logic [DATA_WIDTH-1:0]  cpu_write_data,
    input  logic                   cpu_write_enable,
    input  logic [DATA_WIDTH-1:0]  data_read_from_memory,
    output logic [DATA_WIDTH-1:0]  original_address,
    output logic [DATA_WIDTH-1:0]  MemOut,
    output logic                   allow_write_on_memory,
    output logic                   busy,
    output logic                   done
);

    import armaria_mem_pkg::*;

    copy_state_e            state_q,  state_d;
    logic [DATA_WIDTH-1:0]  src_q,    src_d;
    logic [DATA_WIDTH-1:0]  dst_q,    dst_d;
    logic [COUNT_WIDTH-1:0] count_q,  count_d;
    logic [DATA_WIDTH-1:0]  buffer_q, buffer_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;

    logic [DATA_WIDTH-1:0]  eng_address;
    logic [DATA_WIDTH-1:0]  eng_write_data;
    logic                   eng_write_enable;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        count_d  = count_q;
        buffer_d = buffer_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            COPY_IDLE: begin
                if (start) begin
                    src_d   = src_address;
                    dst_d   = dst_address;
                    count_d = word_count;
                    busy_d  = 1'b1;
                    state_d = (word_count == '0) ? COPY_FINISH : COPY_READ;
                end
            end
            COPY_READ: begin
                if (!cpu_request) state_d = COPY_LATCH;
            end
            COPY_LATCH: begin
                // A CPU cycle here overwrote the port address, so the returned word is not ours.
                if (!cpu_request) begin
                    buffer_d = data_read_from_memory;
                    state_d  = COPY_WRITE;
                end else begin
                    state_d = COPY_READ;
                end
            end
            COPY_WRITE: begin
                if (!cpu_request) begin
                    src_d   = src_q + DATA_WIDTH'(1);
                    dst_d   = dst_q + DATA_WIDTH'(1);
                    count_d = count_q - COUNT_WIDTH'(1);
                    if (count_d == '0) begin
                        state_d = COPY_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = COPY_READ;
                    end
                end
            end
            COPY_FINISH: begin
                // Zero-length copies arrive here still busy and complete one cycle later.
                state_d = COPY_IDLE;
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: state_d = COPY_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; buffer is cleared on reset too.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q  <= COPY_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            count_q  <= '0;
            buffer_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            count_q  <= count_d;
            buffer_q <= buffer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Engine drive is masked during reset so an in-flight copy cannot store in the reset cycle.
    always_comb begin
        eng_address      = '0;
        eng_write_data   = '0;
        eng_write_enable = 1'b0;
        if (!reset) begin
            case (state_q)
                COPY_READ, COPY_LATCH: eng_address = src_q;
                COPY_WRITE: begin
                    eng_address      = dst_q;
                    eng_write_data   = buffer_q;
                    eng_write_enable = 1'b1;
                end
                default: eng_address = '0;
            endcase
        end
    end

    memory_port_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_mux (
        .cpu_request_i       (cpu_request),
        .cpu_address_i       (cpu_address),
        .cpu_write_data_i    (cpu_write_data),
        .cpu_write_enable_i  (cpu_write_enable),
        .eng_address_i       (eng_address),
        .eng_write_data_i    (eng_write_data),
        .eng_write_enable_i  (eng_write_enable),
        .port_address_o      (original_address),
        .port_write_data_o   (MemOut),
        .port_write_enable_o (allow_write_on_memory)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_storage_copy_engine.sv
// Directed bench for storage_copy_engine with a patterned read-data memory model and a port write log.
module tb_storage_copy_engine;

    localparam int DW = 32;
    localparam int CW = 14;

    logic          slow_clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] src_address = '0;
    logic [DW-1:0] dst_address = '0;
    logic [CW-1:0] word_count = '0;
    logic          cpu_request = 1'b0;
    logic [DW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_write_data = '0;
    logic          cpu_write_enable = 1'b0;
    logic [DW-1:0] data_read_from_memory = '0;
    logic [DW-1:0] original_address;
    logic [DW-1:0] MemOut;
    logic          allow_write_on_memory;
    logic          busy;
    logic          done;

    storage_copy_engine #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .slow_clock            (slow_clock),
        .reset                 (reset),
        .start                 (start),
        .src_address           (src_address),
        .dst_address           (dst_address),
        .word_count            (word_count),
        .cpu_request           (cpu_request),
        .cpu_address           (cpu_address),
        .cpu_write_data        (cpu_write_data),
        .cpu_write_enable      (cpu_write_enable),
        .data_read_from_memory (data_read_from_memory),
        .original_address      (original_address),
        .MemOut                (MemOut),
        .allow_write_on_memory (allow_write_on_memory),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    wr_t wlog[$];
    int  dlog[$];
    bit  busy_hist[int];
    wr_t mon_w;

    function automatic logic [31:0] mem_pattern(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge slow_clock) cyc <= cyc + 1;

    // Memory model: read data for the address driven in a cycle is valid the following cycle.
    always @(posedge slow_clock) data_read_from_memory <= mem_pattern(original_address);

    always @(negedge slow_clock) begin
        if (allow_write_on_memory === 1'b1) begin
            mon_w.cyc  = cyc;
            mon_w.addr = original_address;
            mon_w.data = MemOut;
            wlog.push_back(mon_w);
        end
        if (done === 1'b1) dlog.push_back(cyc);
        busy_hist[cyc] = busy;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge slow_clock);
            #1;
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
        busy_hist.delete();
    endtask

    task automatic begin_copy(input logic [31:0] s, input logic [31:0] d, input logic [13:0] c,
                              output int t);
        start       = 1'b1;
        src_address = s;
        dst_address = d;
        word_count  = c;
        t           = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (dlog.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        if (dlog.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        @(negedge slow_clock);
        n_checks++;
        if ({original_address, MemOut, allow_write_on_memory, busy, done} !== {64'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_idle: got addr=%h data=%h we=%b busy=%b done=%b, expected all zero",
                     original_address, MemOut, allow_write_on_memory, busy, done);
        end
        cpu_request      = 1'b1;
        cpu_address      = 32'h0000_0055;
        cpu_write_data   = 32'h0000_0066;
        cpu_write_enable = 1'b1;
        @(negedge slow_clock);
        n_checks++;
        if ({original_address, MemOut, allow_write_on_memory} !== {32'h55, 32'h66, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_cpu_passthrough: got addr=%h data=%h we=%b, expected 00000055 00000066 1",
                     original_address, MemOut, allow_write_on_memory);
        end
        tick();
        cpu_request      = 1'b0;
        cpu_write_enable = 1'b0;
        reset            = 1'b0;
        tick(2);
        @(negedge slow_clock);
        n_checks++;
        if ({original_address, allow_write_on_memory, busy, done} !== {32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL post_reset_idle: got addr=%h we=%b busy=%b done=%b, expected zeros",
                     original_address, allow_write_on_memory, busy, done);
        end
        tick();
    endtask

    task automatic test_basic_copy();
        int  t;
        bit  busy_ok;
        wr_t e;
        wr_t exp_q[$];
        clear_logs();
        begin_copy(32'h4000, 32'h100, 14'd4, t);
        wait_done(40, "basic");
        for (int i = 0; i < 4; i++) begin
            e.cyc = t + 3 + 3 * i; e.addr = 32'h100 + i; e.data = mem_pattern(32'h4000 + i);
            exp_q.push_back(e);
        end
        n_checks++;
        if (wlog.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d, expected %0d", wlog.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].cyc !== exp_q[i].cyc || wlog[i].addr !== exp_q[i].addr || wlog[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL basic_write%0d: got t+%0d %h<=%h, expected t+%0d %h<=%h", i,
                         wlog[i].cyc - t, wlog[i].addr, wlog[i].data, exp_q[i].cyc - t, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_checks++;
        if (dlog.size() !== 1 || dlog[0] !== t + 13) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses, first at t+%0d, expected 1 at t+13",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] - t : -1);
        end
        busy_ok = (busy_hist[t] === 1'b0) && (busy_hist[t + 13] === 1'b0);
        for (int c = t + 1; c <= t + 12; c++) if (busy_hist[c] !== 1'b1) busy_ok = 1'b0;
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL basic_busy: got busy window wrong, expected low at t and t+13, high t+1..t+12");
        end
    endtask

    task automatic test_zero_count();
        int t;
        clear_logs();
        begin_copy(32'h1234, 32'h5678, 14'd0, t);
        wait_done(10, "zero");
        n_checks++;
        if (wlog.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_no_write: got %0d writes, expected 0", wlog.size());
        end
        n_checks++;
        if (dlog.size() !== 1 || dlog[0] !== t + 2 || busy_hist[t + 1] !== 1'b1 || busy_hist[t + 2] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got %0d pulses first at t+%0d busy(t+1)=%b busy(t+2)=%b, expected 1 at t+2, 1, 0",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] - t : -1, busy_hist[t + 1], busy_hist[t + 2]);
        end
    endtask

    task automatic test_cpu_in_latch();
        int  t;
        wr_t e;
        wr_t exp_q[$];
        clear_logs();
        begin_copy(32'h200, 32'h300, 14'd3, t);
        tick(4);
        cpu_request      = 1'b1;
        cpu_address      = 32'h7000;
        cpu_write_data   = 32'h1234_5678;
        cpu_write_enable = 1'b1;
        tick();
        cpu_request      = 1'b0;
        cpu_write_enable = 1'b0;
        wait_done(40, "latch");
        e.cyc = t + 3;  e.addr = 32'h300;  e.data = mem_pattern(32'h200);  exp_q.push_back(e);
        e.cyc = t + 5;  e.addr = 32'h7000; e.data = 32'h1234_5678;         exp_q.push_back(e);
        e.cyc = t + 8;  e.addr = 32'h301;  e.data = mem_pattern(32'h201);  exp_q.push_back(e);
        e.cyc = t + 11; e.addr = 32'h302;  e.data = mem_pattern(32'h202);  exp_q.push_back(e);
        n_checks++;
        if (wlog.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL latch_write_count: got %0d, expected %0d", wlog.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].cyc !== exp_q[i].cyc || wlog[i].addr !== exp_q[i].addr || wlog[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL latch_write%0d: got t+%0d %h<=%h, expected t+%0d %h<=%h", i,
                         wlog[i].cyc - t, wlog[i].addr, wlog[i].data, exp_q[i].cyc - t, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_checks++;
        if (dlog.size() !== 1 || dlog[0] !== t + 12) begin
            n_fail++;
            $display("FAIL latch_done: got first at t+%0d, expected t+12", (dlog.size() > 0) ? dlog[0] - t : -1);
        end
    endtask

    task automatic test_cpu_hold_write();
        int  t;
        wr_t e;
        wr_t exp_q[$];
        clear_logs();
        begin_copy(32'h500, 32'h600, 14'd2, t);
        tick(2);
        cpu_request      = 1'b1;
        cpu_address      = 32'h9999;
        cpu_write_enable = 1'b0;
        tick(5);
        cpu_request = 1'b0;
        wait_done(40, "hold");
        e.cyc = t + 8;  e.addr = 32'h600; e.data = mem_pattern(32'h500); exp_q.push_back(e);
        e.cyc = t + 11; e.addr = 32'h601; e.data = mem_pattern(32'h501); exp_q.push_back(e);
        n_checks++;
        if (wlog.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL hold_write_count: got %0d, expected %0d", wlog.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].cyc !== exp_q[i].cyc || wlog[i].addr !== exp_q[i].addr || wlog[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL hold_write%0d: got t+%0d %h<=%h, expected t+%0d %h<=%h", i,
                         wlog[i].cyc - t, wlog[i].addr, wlog[i].data, exp_q[i].cyc - t, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_checks++;
        if (dlog.size() !== 1 || dlog[0] !== t + 12) begin
            n_fail++;
            $display("FAIL hold_done: got first at t+%0d, expected t+12", (dlog.size() > 0) ? dlog[0] - t : -1);
        end
    endtask

    task automatic test_address_wrap();
        int  t;
        wr_t e;
        wr_t exp_q[$];
        clear_logs();
        begin_copy(32'hFFFF_FFFF, 32'h10, 14'd2, t);
        wait_done(20, "wrap");
        e.cyc = t + 3; e.addr = 32'h10; e.data = 32'hA5A5_3C3C; exp_q.push_back(e);
        e.cyc = t + 6; e.addr = 32'h11; e.data = 32'h5A5A_C3C3; exp_q.push_back(e);
        n_checks++;
        if (wlog.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_write_count: got %0d, expected %0d", wlog.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].cyc !== exp_q[i].cyc || wlog[i].addr !== exp_q[i].addr || wlog[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL wrap_write%0d: got t+%0d %h<=%h, expected t+%0d %h<=%h", i,
                         wlog[i].cyc - t, wlog[i].addr, wlog[i].data, exp_q[i].cyc - t, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_busy_start_then_reset();
        int t;
        clear_logs();
        begin_copy(32'h800, 32'h900, 14'd5, t);
        start       = 1'b1;
        src_address = 32'hAAAA_0000;
        dst_address = 32'hBBBB_0000;
        word_count  = 14'd1;
        tick();
        start = 1'b0;
        tick(4);
        reset = 1'b1;
        @(negedge slow_clock);
        n_checks++;
        if (allow_write_on_memory !== 1'b0 || original_address !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_write_suppressed: got we=%b addr=%h, expected 0 00000000",
                     allow_write_on_memory, original_address);
        end
        tick();
        reset = 1'b0;
        @(negedge slow_clock);
        n_checks++;
        if ({busy, done, allow_write_on_memory, original_address} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL abandon_idle: got busy=%b done=%b we=%b addr=%h, expected all zero",
                     busy, done, allow_write_on_memory, original_address);
        end
        tick(30);
        n_checks++;
        if (wlog.size() !== 1 || wlog[0].cyc !== t + 3 || wlog[0].addr !== 32'h900 || wlog[0].data !== mem_pattern(32'h800)) begin
            n_fail++;
            $display("FAIL abandon_writes: got %0d writes (first t+%0d %h), expected 1 at t+3 to 00000900",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].cyc - t : -1, (wlog.size() > 0) ? wlog[0].addr : 32'h0);
        end
        n_checks++;
        if (dlog.size() !== 0) begin
            n_fail++;
            $display("FAIL abandon_no_done: got %0d done pulses, expected 0", dlog.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_count();
        test_cpu_in_latch();
        test_cpu_hold_write();
        test_address_wrap();
        test_busy_start_then_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/storage_copy_engine.md
# storage_copy_engine

Block-copy sequencer and data-port arbiter in front of the memory unit. It copies `word_count` consecutive words from a source address range (storage or main memory) to a destination range. It shares the single data port (`original_address` / `MemOut` / `allow_write_on_memory` / `data_read_from_memory`) with the CPU, and the CPU always has priority. It is used to load programs from the storage drive into main memory after BIOS hand-off.

## Interface
- `DATA_WIDTH`, 32, data and address width of the memory unit data port
- `COUNT_WIDTH`, 14, width of the word counter (max 2^14-1 words per copy)

- `slow_clock`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a copy; sampled only in IDLE
- `src_address`  in  DATA_WIDTH  first source word address, latched at start
- `dst_address`  in  DATA_WIDTH  first destination word address, latched at start
- `word_count`  in  COUNT_WIDTH  number of words to copy, latched at start
- `cpu_request`  in  1  CPU drives the data port this cycle
- `cpu_address`  in  DATA_WIDTH  CPU data address
- `cpu_write_data`  in  DATA_WIDTH  CPU store data
- `cpu_write_enable`  in  1  CPU store strobe
- `data_read_from_memory`  in  DATA_WIDTH  memory unit read data; valid the cycle after the address is driven
- `original_address`  out  DATA_WIDTH  data port address to the memory unit
- `MemOut`  out  DATA_WIDTH  data port write data
- `allow_write_on_memory`  out  1  data port write enable
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle pulse when the copy completes

## Operation
- States: IDLE, READ, LATCH, WRITE, FINISH.
- IDLE:
  - `start`=1 latches `src`, `dst` and `count`.
  - If `count`=0, go to FINISH.
  - Otherwise go to READ.
- READ: when the engine has the port (`cpu_request`=0), drive `original_address`=`src`, write enable 0, then go to LATCH. If the CPU has the port, stay in READ.
- LATCH:
  - If `cpu_request`=0: capture `data_read_from_memory` into `buffer`, then go to WRITE.
  - If `cpu_request`=1: the read data is invalid. Go back to READ with `src` unchanged.
  - The engine drives `original_address`=`src` in LATCH.
- WRITE:
  - If `cpu_request`=0: drive `original_address`=`dst`, `MemOut`=`buffer`, `allow_write_on_memory`=1. Then `src`+1, `dst`+1, `count`-1.
  - After the write, if the new `count` is 0, go to FINISH; otherwise go to READ.
  - If `cpu_request`=1: stay in WRITE. `buffer` is held.
- FINISH: assert `done` for one cycle, deassert `busy`, go to IDLE.
- Port mux:
  - `cpu_request`=1 passes the CPU address, data and write enable straight through, in any state.
  - Otherwise the engine's drive is used.
  - In IDLE and FINISH with no CPU request, outputs are 0.
- Addresses increment by 1 (word addressed) and wrap modulo 2^DATA_WIDTH without error. Source and destination may be in different memory regions; region selection belongs to the downstream memory controller.
- `start` while `busy` is ignored. There is no abort input.
- The CPU has strict priority, so a CPU that requests the port continuously starves the engine. This is accepted.

## Timing
- Reset:
  - State goes to IDLE.
  - `busy`=0, `done`=0.
  - `src`, `dst`, `count` and `buffer` go to 0.
  - Port outputs follow the CPU inputs if `cpu_request`=1, otherwise 0.
- Reset mid-copy: the copy is abandoned and there is no `done` pulse. A write in the reset cycle is suppressed unless it is a CPU write.
- Best case is 3 cycles per word with no contention. An N-word copy runs from the `start` cycle t to `done` at t+1+3N+… : the first READ is at t+1, the last WRITE at t+3N, and `done` at t+3N+1.
- `count`=0: `done` at t+2 with no memory access.
- `busy` is high from t+1 through the cycle before `done`, and low in the `done` cycle.
- Each CPU-request cycle adds at least one cycle. A request during LATCH costs a full re-read (+2 cycles).

## Structure
- Shared package `armaria_mem_pkg` holds:
  - the state enum (`COPY_IDLE` … `COPY_FINISH`)
  - the default widths `DATA_WIDTH`=32 and `COUNT_WIDTH`=14
- One sub-module, `memory_port_mux`: a combinational priority mux that selects between the CPU and engine drive. It is reusable for future port requesters.

## Test plan
- Reset, then `start` with `src`=0x4000, `dst`=0x100, `count`=4, no CPU traffic → four writes to 0x100–0x103 with the source data. `done` pulses at t+13. `busy` is high t+1..t+12.
- `count`=0 → no `allow_write_on_memory`, `done` at t+2.
- `cpu_request` pulsed in the LATCH cycle of word 2 → word 2 is re-read from the same `src`, the destination data is correct, and `done` is delayed by 2 cycles. The CPU store appears on the port in the pulse cycle.
- `cpu_request` held for 5 cycles during WRITE → `buffer` is held, no engine write occurs, and the write completes the cycle after release.
- `src`=0xFFFFFFFF, `count`=2 → the second read is from 0x00000000.
- `start` pulsed while busy, then `reset` mid-copy → the second start is ignored. After reset: IDLE, `busy`=0, no `done`, no further engine writes.
